// File: rtl/cache_controller_if.sv
// CPU, cache-array and memory signal bundle for the cache sequencer.
// Pure wiring; adds no latency.
// Flow control lives in the protocol: cpu_ready pulse, mem_req/mem_ack hold.
interface cache_controller_if #(
    parameter int CASHENTRIES = 256,
    parameter int WAYS        = 4,
    parameter int DATALENGTH  = 32,
    parameter int TAGLENGTH   = 8,
    parameter int CNTLENGTH   = 16
);
    localparam int INDEXLENGTH = $clog2(CASHENTRIES / WAYS);
    localparam int ADDRLENGTH  = TAGLENGTH + INDEXLENGTH;

    // CPU side
    logic                   cpu_req;
    logic                   cpu_we;
    logic [ADDRLENGTH-1:0]  cpu_addr;
    logic [DATALENGTH-1:0]  cpu_wdata;
    logic [DATALENGTH-1:0]  cpu_rdata;
    logic                   cpu_ready;
    logic                   cfg_enable;
    logic                   stats_clr;
    logic [CNTLENGTH-1:0]   hit_count;
    logic [CNTLENGTH-1:0]   miss_count;

    // Cache array side
    logic [TAGLENGTH-1:0]   c_tag;
    logic [INDEXLENGTH-1:0] c_index;
    logic [DATALENGTH-1:0]  c_datain;
    logic                   c_re;
    logic                   c_we;
    logic                   c_loade;
    logic                   c_enable;
    logic                   c_hit;
    logic [DATALENGTH-1:0]  c_dataout;

    // Memory side
    logic                   mem_req;
    logic                   mem_we;
    logic [ADDRLENGTH-1:0]  mem_addr;
    logic [DATALENGTH-1:0]  mem_wdata;
    logic                   mem_ack;
    logic [DATALENGTH-1:0]  mem_rdata;

    // Controller view
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cfg_enable, stats_clr,
        output cpu_rdata, cpu_ready, hit_count, miss_count,
        output c_tag, c_index, c_datain, c_re, c_we, c_loade, c_enable,
        input  c_hit, c_dataout,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    // Environment view (CPU, cache array and memory together)
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cfg_enable, stats_clr,
        input  cpu_rdata, cpu_ready, hit_count, miss_count,
        input  c_tag, c_index, c_datain, c_re, c_we, c_loade, c_enable,
        output c_hit, c_dataout,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/cache_controller.sv
// Sequencer between CPU, set-associative cache array and word memory (write-through, no-write-allocate, bypass mode).
// Latency: read hit 3, read miss 4+memory waits, write 3+waits, bypass 2+waits cycles to cpu_ready.
// One request at a time: cpu_req is only looked at in IDLE; memory stalls hold mem_req until mem_ack.
module cache_controller #(
    parameter int CASHENTRIES = 256,
    parameter int WAYS        = 4,
    parameter int DATALENGTH  = 32,
    parameter int TAGLENGTH   = 8,
    parameter int CNTLENGTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    cache_controller_if.slave  bus
);
    localparam int INDEXLENGTH = $clog2(CASHENTRIES / WAYS);
    localparam int ADDRLENGTH  = TAGLENGTH + INDEXLENGTH;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, RD_HIT, MEM_RD, FILL, MEM_WR, RESPOND
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   we_q;
    logic                   mode_q;
    logic [ADDRLENGTH-1:0]  addr_q;
    logic [DATALENGTH-1:0]  wdata_q;
    logic [DATALENGTH-1:0]  rdata_q;
    logic [CNTLENGTH-1:0]   hit_cnt;
    logic [CNTLENGTH-1:0]   miss_cnt;

    logic                   c_re;
    logic                   c_we;
    logic                   c_loade;
    logic                   c_enable;
    logic [DATALENGTH-1:0]  c_datain;
    logic                   mem_req;
    logic                   mem_we;
    logic                   cpu_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and per-state strobes; the cache is only touched in cached-mode states
    always_comb begin
        state_nxt = state;
        c_re      = 1'b0;
        c_we      = 1'b0;
        c_loade   = 1'b0;
        c_enable  = 1'b0;
        c_datain  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        cpu_ready = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.cpu_req) begin
                    if (bus.cfg_enable) state_nxt = LOOKUP;
                    else if (bus.cpu_we) state_nxt = MEM_WR;
                    else                 state_nxt = MEM_RD;
                end
            end
            LOOKUP: begin
                c_enable = 1'b1;
                c_re     = ~we_q;
                c_we     = we_q;
                c_datain = wdata_q;
                if (we_q)           state_nxt = MEM_WR;
                else if (bus.c_hit) state_nxt = RD_HIT;
                else                state_nxt = MEM_RD;
            end
            RD_HIT: state_nxt = RESPOND;
            MEM_RD: begin
                mem_req = 1'b1;
                if (bus.mem_ack) state_nxt = mode_q ? FILL : RESPOND;
            end
            FILL: begin
                c_enable  = 1'b1;
                c_loade   = 1'b1;
                c_datain  = rdata_q;
                state_nxt = RESPOND;
            end
            MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (bus.mem_ack) state_nxt = RESPOND;
            end
            RESPOND: begin
                cpu_ready = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture at acceptance; held stable for the whole transaction
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q    <= 1'b0;
            mode_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && bus.cpu_req) begin
            we_q    <= bus.cpu_we;
            mode_q  <= bus.cfg_enable;
            addr_q  <= bus.cpu_addr;
            wdata_q <= bus.cpu_wdata;
        end
    end

    // Read data register doubles as the fill buffer; writes never touch it
    always_ff @(posedge clk) begin
        if (reset)                            rdata_q <= '0;
        else if (state == RD_HIT)             rdata_q <= bus.c_dataout;
        else if (state == MEM_RD && bus.mem_ack) rdata_q <= bus.mem_rdata;
    end

    // Saturating hit/miss counters, only cached lookups count, clear wins
    always_ff @(posedge clk) begin
        if (reset || bus.stats_clr) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == LOOKUP) begin
            if (bus.c_hit) begin
                if (hit_cnt != '1) hit_cnt <= hit_cnt + CNTLENGTH'(1);
            end else begin
                if (miss_cnt != '1) miss_cnt <= miss_cnt + CNTLENGTH'(1);
            end
        end
    end

    assign bus.c_tag      = addr_q[ADDRLENGTH-1 -: TAGLENGTH];
    assign bus.c_index    = addr_q[INDEXLENGTH-1:0];
    assign bus.c_datain   = c_datain;
    assign bus.c_re       = c_re;
    assign bus.c_we       = c_we;
    assign bus.c_loade    = c_loade;
    assign bus.c_enable   = c_enable;
    assign bus.mem_req    = mem_req;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.cpu_ready  = cpu_ready;
    assign bus.cpu_rdata  = rdata_q;
    assign bus.hit_count  = hit_cnt;
    assign bus.miss_count = miss_cnt;
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a behavioural cache array and memory.
// Expected responses are queued per request and checked by a separate monitor.
// Memory wait cycles are programmable per transaction.
module tb_cache_controller;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    cache_controller_if #(.CASHENTRIES(256), .WAYS(4), .DATALENGTH(32),
                          .TAGLENGTH(8), .CNTLENGTH(16)) bus_if();

    cache_controller #(.CASHENTRIES(256), .WAYS(4), .DATALENGTH(32),
                       .TAGLENGTH(8), .CNTLENGTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] rdata;
        int          start;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- memory model ----------------
    int          mem_wait = 0;
    int          wcnt = 0;
    logic [31:0] mem_arr [16384];
    bit          mem_wr  [16384];

    function automatic logic [31:0] mem_val(input logic [13:0] a);
        if (mem_wr[a]) return mem_arr[a];
        case (a)
            14'h1A5: return 32'hDEADBEEF;
            14'h3FF: return 32'hCAFEF00D;
            default: return {18'h0, a};
        endcase
    endfunction

    always_comb begin
        bus_if.mem_ack   = bus_if.mem_req && (wcnt >= mem_wait);
        bus_if.mem_rdata = mem_val(bus_if.mem_addr);
    end

    always @(posedge clk) begin
        if (!bus_if.mem_req || bus_if.mem_ack) wcnt <= 0;
        else                                   wcnt <= wcnt + 1;
        if (bus_if.mem_req && bus_if.mem_ack && bus_if.mem_we) begin
            mem_arr[bus_if.mem_addr] <= bus_if.mem_wdata;
            mem_wr[bus_if.mem_addr]  <= 1'b1;
        end
    end

    // ---------------- cache array model ----------------
    bit          cv  [64][4];
    logic [7:0]  ct  [64][4];
    logic [31:0] cd  [64][4];
    bit   [1:0]  vic [64];
    logic [31:0] cdout = 32'h0;
    logic        chit;
    int          hway;

    always_comb begin
        chit = 1'b0;
        hway = 0;
        for (int w = 0; w < 4; w++) begin
            if (cv[bus_if.c_index][w] && ct[bus_if.c_index][w] == bus_if.c_tag) begin
                chit = 1'b1;
                hway = w;
            end
        end
        bus_if.c_hit     = chit;
        bus_if.c_dataout = cdout;
    end

    always @(posedge clk) begin
        if (bus_if.c_enable) begin
            if (bus_if.c_re && chit) cdout <= cd[bus_if.c_index][hway];
            if (bus_if.c_we && chit) cd[bus_if.c_index][hway] <= bus_if.c_datain;
            if (bus_if.c_loade) begin
                cv[bus_if.c_index][vic[bus_if.c_index]] <= 1'b1;
                ct[bus_if.c_index][vic[bus_if.c_index]] <= bus_if.c_tag;
                cd[bus_if.c_index][vic[bus_if.c_index]] <= bus_if.c_datain;
                vic[bus_if.c_index] <= vic[bus_if.c_index] + 2'd1;
            end
        end
    end

    // ---------------- monitor ----------------
    int          done_n = 0, rdy_n = 0, ld_n = 0, mreq_n = 0, mwr_n = 0, cact_n = 0, cwe_n = 0;
    int          cwe_cyc = 0;
    logic [7:0]  ld_tag = 8'h0;
    logic [5:0]  ld_idx = 6'h0;
    logic [31:0] last_mwdata = 32'h0;

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (bus_if.c_loade) begin
            ld_n++;
            ld_tag = bus_if.c_tag;
            ld_idx = bus_if.c_index;
        end
        if (bus_if.mem_req) begin
            mreq_n++;
            if (bus_if.mem_we) begin
                mwr_n++;
                last_mwdata = bus_if.mem_wdata;
            end
        end
        if (bus_if.c_enable || bus_if.c_re || bus_if.c_we || bus_if.c_loade) cact_n++;
        if (bus_if.c_we) begin
            cwe_n++;
            cwe_cyc = cyc;
        end
        if (bus_if.cpu_ready) begin
            rdy_n++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready: cpu_ready=1 at cycle %0d with no request pending", cyc);
            end else begin
                e = sbq.pop_front();
                check("cpu_rdata", bus_if.cpu_rdata, e.rdata);
                check("latency", 32'(cyc - e.start), 32'(e.lat));
                done_n++;
            end
        end
    end

    // ---------------- stimulus ----------------
    int cur_start = 0;

    task automatic run_txn(input logic we, input logic [13:0] addr, input logic [31:0] wd,
                           input logic en, input logic clr, input logic [31:0] exp_rd,
                           input int exp_lat);
        exp_t e;
        int   d0;
        int   t;
        @(negedge clk);
        bus_if.cpu_req    = 1'b1;
        bus_if.cpu_we     = we;
        bus_if.cpu_addr   = addr;
        bus_if.cpu_wdata  = wd;
        bus_if.cfg_enable = en;
        e.rdata = exp_rd;
        e.start = cyc;
        e.lat   = exp_lat;
        cur_start = cyc;
        d0 = done_n;
        sbq.push_back(e);
        @(negedge clk);
        bus_if.cpu_req   = 1'b0;
        bus_if.stats_clr = clr;
        @(negedge clk);
        bus_if.stats_clr = 1'b0;
        t = 0;
        while (done_n == d0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (done_n == d0) begin
            checks++;
            failures++;
            $display("FAIL txn_timeout: no cpu_ready within 40 cycles for addr %h", addr);
            sbq.delete();
        end
    endtask

    int s_ld, s_mreq, s_mwr, s_cact, s_rdy;

    task automatic snap();
        s_ld = ld_n; s_mreq = mreq_n; s_mwr = mwr_n; s_cact = cact_n; s_rdy = rdy_n;
    endtask

    initial begin
        bus_if.cpu_req    = 1'b0;
        bus_if.cpu_we     = 1'b0;
        bus_if.cpu_addr   = '0;
        bus_if.cpu_wdata  = '0;
        bus_if.cfg_enable = 1'b1;
        bus_if.stats_clr  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_ready", 32'(bus_if.cpu_ready), 32'h0);
        check("rst_mem_req", 32'(bus_if.mem_req), 32'h0);
        check("rst_c_enable", 32'(bus_if.c_enable), 32'h0);
        check("rst_cpu_rdata", bus_if.cpu_rdata, 32'h0);
        check("rst_hit_count", 32'(bus_if.hit_count), 32'h0);
        check("rst_miss_count", 32'(bus_if.miss_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Cold read miss, memory answers after 2 wait cycles
        mem_wait = 2;
        snap();
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 6);
        check("miss_fill_loade", 32'(ld_n - s_ld), 32'd1);
        check("miss_fill_tag", 32'(ld_tag), 32'h06);
        check("miss_fill_index", 32'(ld_idx), 32'h25);
        check("miss_count_1", 32'(bus_if.miss_count), 32'd1);
        mem_wait = 0;

        // Repeat read hits
        snap();
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'hDEADBEEF, 3);
        check("hit_no_memreq", 32'(mreq_n - s_mreq), 32'd0);
        check("hit_count_1", 32'(bus_if.hit_count), 32'd1);

        // Write hit, write-through; rdata register keeps the last read
        snap();
        run_txn(1'b1, 14'h1A5, 32'h12345678, 1'b1, 1'b0, 32'hDEADBEEF, 3);
        check("wr_hit_cwe_once", 32'(cwe_n), 32'd1);
        check("wr_hit_cwe_in_lookup", 32'(cwe_cyc - cur_start), 32'd1);
        check("wr_hit_mem_writes", 32'(mwr_n - s_mwr), 32'd1);
        check("wr_hit_mem_wdata", last_mwdata, 32'h12345678);
        check("wr_hit_mem_content", mem_val(14'h1A5), 32'h12345678);
        check("hit_count_2", 32'(bus_if.hit_count), 32'd2);

        snap();
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'h12345678, 3);
        check("rd_after_wr_no_memreq", 32'(mreq_n - s_mreq), 32'd0);

        // Write miss on a cold line: memory written, no allocation
        snap();
        run_txn(1'b1, 14'h3FF, 32'h0BADF00D, 1'b1, 1'b0, 32'h12345678, 3);
        check("wr_miss_no_loade", 32'(ld_n - s_ld), 32'd0);
        check("wr_miss_mem_content", mem_val(14'h3FF), 32'h0BADF00D);
        check("miss_count_2", 32'(bus_if.miss_count), 32'd2);

        snap();
        run_txn(1'b0, 14'h3FF, 32'h0, 1'b1, 1'b0, 32'h0BADF00D, 4);
        check("rd_after_wr_miss_fill", 32'(ld_n - s_ld), 32'd1);
        check("miss_count_3", 32'(bus_if.miss_count), 32'd3);

        // Bypass read and write
        snap();
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b0, 1'b0, 32'h12345678, 2);
        run_txn(1'b1, 14'h100, 32'h55AA55AA, 1'b0, 1'b0, 32'h12345678, 2);
        check("bypass_cache_idle", 32'(cact_n - s_cact), 32'd0);
        check("bypass_mem_content", mem_val(14'h100), 32'h55AA55AA);
        check("bypass_hit_unchanged", 32'(bus_if.hit_count), 32'd3);
        check("bypass_miss_unchanged", 32'(bus_if.miss_count), 32'd3);

        // Reset while waiting on memory in a read miss
        mem_wait = 1000;
        snap();
        @(negedge clk);
        bus_if.cpu_req    = 1'b1;
        bus_if.cpu_we     = 1'b0;
        bus_if.cpu_addr   = 14'h2C0;
        bus_if.cfg_enable = 1'b1;
        @(negedge clk);
        bus_if.cpu_req = 1'b0;
        @(negedge clk);
        check("midmiss_mem_req_up", 32'(bus_if.mem_req), 32'h1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midmiss_mem_req_drop", 32'(bus_if.mem_req), 32'h0);
        check("midmiss_c_enable", 32'(bus_if.c_enable), 32'h0);
        check("midmiss_rdata_clr", bus_if.cpu_rdata, 32'h0);
        check("midmiss_miss_clr", 32'(bus_if.miss_count), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        mem_wait = 0;
        repeat (6) @(negedge clk);
        check("midmiss_no_ready", 32'(rdy_n - s_rdy), 32'd0);
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'h12345678, 3);
        check("post_reset_hit", 32'(bus_if.hit_count), 32'd1);

        // Saturation from a preloaded near-full hit counter
        @(negedge clk);
        force dut.hit_cnt = 16'hFFFE;
        #1;
        release dut.hit_cnt;
        #1;
        check("sat_preload", 32'(bus_if.hit_count), 32'h0000FFFE);
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'h12345678, 3);
        check("sat_reach", 32'(bus_if.hit_count), 32'h0000FFFF);
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'h12345678, 3);
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b0, 32'h12345678, 3);
        check("sat_hold", 32'(bus_if.hit_count), 32'h0000FFFF);

        // Clear asserted exactly in the LOOKUP cycle of a hit
        run_txn(1'b0, 14'h1A5, 32'h0, 1'b1, 1'b1, 32'h12345678, 3);
        check("clr_beats_hit", 32'(bus_if.hit_count), 32'h0);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
